// File: rtl/pc_fetch_controller.sv
// Front-end sequencer for the 64-bit PC unit: chooses advance/hold/redirect each cycle
// and drives IF/ID write/flush and ID/EX bubble for hazards, stalls, branches and halt.
module pc_fetch_controller #(
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned REG_W  = 5,
    parameter int unsigned CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              imem_ready,
    input  logic              dmem_busy,
    input  logic [REG_W-1:0]  id_rs1,
    input  logic [REG_W-1:0]  id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic              ex_mem_read,
    input  logic [REG_W-1:0]  ex_rd,
    input  logic              ex_branch_taken,
    input  logic [ADDR_W-1:0] ex_branch_target,
    input  logic              id_halt,
    output logic              pc_write,
    output logic              pc_branch_taken,
    output logic [ADDR_W-1:0] pc_branch_target,
    output logic              ifid_write,
    output logic              ifid_flush,
    output logic              idex_bubble,
    output logic              halted,
    output logic [CNT_W-1:0]  stall_cycles,
    output logic [CNT_W-1:0]  redirect_count
);

    typedef enum logic [1:0] {
        RUN           = 2'd0,
        PEND_REDIRECT = 2'd1,
        HALTED        = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] target_q, target_d;
    logic [CNT_W-1:0]  stall_q, stall_d;
    logic [CNT_W-1:0]  redir_q, redir_d;
    logic              lu_c;

    assign lu_c = ex_mem_read & (ex_rd != '0) &
                  ((id_use_rs1 & (ex_rd == id_rs1)) | (id_use_rs2 & (ex_rd == id_rs2)));

    assign stall_cycles   = stall_q;
    assign redirect_count = redir_q;

    // State, pending target and performance counters
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= RUN;
            target_q <= '0;
            stall_q  <= '0;
            redir_q  <= '0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            stall_q  <= stall_d;
            redir_q  <= redir_d;
        end
    end

    // Next state, control outputs and counter updates
    always_comb begin
        state_d          = state_q;
        target_d         = target_q;
        pc_write         = 1'b0;
        pc_branch_taken  = 1'b0;
        pc_branch_target = '0;
        ifid_write       = 1'b0;
        ifid_flush       = 1'b0;
        idex_bubble      = 1'b0;
        halted           = 1'b0;

        case (state_q)
            RUN: begin
                if (dmem_busy) begin
                    // front end frozen; a held branch is applied once MEM frees up
                end else if (ex_branch_taken && imem_ready) begin
                    pc_write         = 1'b1;
                    pc_branch_taken  = 1'b1;
                    pc_branch_target = ex_branch_target;
                    ifid_flush       = 1'b1;
                    idex_bubble      = 1'b1;
                end else if (ex_branch_taken) begin
                    target_d    = ex_branch_target;
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                    state_d     = PEND_REDIRECT;
                end else if (lu_c) begin
                    idex_bubble = 1'b1;
                end else if (id_halt) begin
                    idex_bubble = 1'b1;
                    state_d     = HALTED;
                end else begin
                    pc_write   = imem_ready;
                    ifid_write = imem_ready;
                    ifid_flush = ~imem_ready;
                end
            end
            PEND_REDIRECT: begin
                ifid_flush  = 1'b1;
                idex_bubble = 1'b1;
                if (imem_ready) begin
                    pc_write         = 1'b1;
                    pc_branch_taken  = 1'b1;
                    pc_branch_target = target_q;
                    target_d         = '0;
                    state_d          = RUN;
                end
            end
            HALTED: begin
                idex_bubble = 1'b1;
                halted      = 1'b1;
            end
            default: state_d = RUN;
        endcase

        if (!reset) begin
            pc_write         = 1'b0;
            pc_branch_taken  = 1'b0;
            pc_branch_target = '0;
            ifid_write       = 1'b0;
            ifid_flush       = 1'b0;
            idex_bubble      = 1'b0;
            halted           = 1'b0;
        end

        stall_d = stall_q;
        if (!pc_write && !halted && (stall_q != '1)) begin
            stall_d = stall_q + CNT_W'(1);
        end
        redir_d = redir_q;
        if (pc_branch_taken && (redir_q != '1)) begin
            redir_d = redir_q + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pc_fetch_controller.sv
// Self-checking bench for pc_fetch_controller: directed scenarios plus randomized
// traffic compared against a behavioural model of the sequencing rules.
module tb_pc_fetch_controller;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        imem_ready, dmem_busy;
    logic [4:0]  id_rs1, id_rs2, ex_rd;
    logic        id_use_rs1, id_use_rs2, ex_mem_read;
    logic        ex_branch_taken, id_halt;
    logic [63:0] ex_branch_target;
    logic        pc_write, pc_branch_taken, ifid_write, ifid_flush, idex_bubble, halted;
    logic [63:0] pc_branch_target;
    logic [31:0] stall_cycles, redirect_count;

    typedef struct packed {
        logic        pw;
        logic        bt;
        logic [63:0] tgt;
        logic        iw;
        logic        fl;
        logic        bub;
        logic        hl;
    } exp_t;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    bit          m_halted, m_pend;
    logic [63:0] m_tgt;
    logic [31:0] m_stall, m_redir;
    logic [63:0] pc;

    pc_fetch_controller dut (
        .clk(clk), .reset(reset), .imem_ready(imem_ready), .dmem_busy(dmem_busy),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken),
        .ex_branch_target(ex_branch_target), .id_halt(id_halt),
        .pc_write(pc_write), .pc_branch_taken(pc_branch_taken),
        .pc_branch_target(pc_branch_target), .ifid_write(ifid_write),
        .ifid_flush(ifid_flush), .idex_bubble(idex_bubble), .halted(halted),
        .stall_cycles(stall_cycles), .redirect_count(redirect_count)
    );

    always #5 clk = ~clk;

    // Simple PC unit driven by the controller outputs
    always @(posedge clk or negedge reset) begin
        if (!reset)          pc <= 64'd0;
        else if (pc_write)   pc <= pc_branch_taken ? pc_branch_target : pc + 64'd4;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", tag, $time, obs, exp);
        end
    endtask

    task automatic set_idle();
        imem_ready = 1'b1; dmem_busy = 1'b0;
        id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
        id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; ex_mem_read = 1'b0;
        ex_branch_taken = 1'b0; ex_branch_target = 64'd0; id_halt = 1'b0;
    endtask

    // One clock cycle: inputs already driven at posedge+1, check mid-cycle, advance model
    task automatic step();
        exp_t        e;
        bit          lu, nh, np;
        logic [63:0] nt;
        #4;
        lu = ex_mem_read && (ex_rd != 5'd0) &&
             ((id_use_rs1 && ex_rd == id_rs1) || (id_use_rs2 && ex_rd == id_rs2));
        e = '0; nh = m_halted; np = m_pend; nt = m_tgt;
        if (m_halted) begin
            e.bub = 1'b1; e.hl = 1'b1;
        end else if (m_pend) begin
            e.fl = 1'b1; e.bub = 1'b1;
            if (imem_ready) begin
                e.pw = 1'b1; e.bt = 1'b1; e.tgt = m_tgt; np = 1'b0;
            end
        end else if (dmem_busy) begin
            e = '0;
        end else if (ex_branch_taken) begin
            e.fl = 1'b1; e.bub = 1'b1;
            if (imem_ready) begin
                e.pw = 1'b1; e.bt = 1'b1; e.tgt = ex_branch_target;
            end else begin
                np = 1'b1; nt = ex_branch_target;
            end
        end else if (lu) begin
            e.bub = 1'b1;
        end else if (id_halt) begin
            e.bub = 1'b1; nh = 1'b1;
        end else begin
            e.pw = imem_ready; e.iw = imem_ready; e.fl = !imem_ready;
        end
        check_eq("pc_write", 64'(pc_write), 64'(e.pw));
        check_eq("pc_branch_taken", 64'(pc_branch_taken), 64'(e.bt));
        check_eq("pc_branch_target", pc_branch_target, e.tgt);
        check_eq("ifid_write", 64'(ifid_write), 64'(e.iw));
        check_eq("ifid_flush", 64'(ifid_flush), 64'(e.fl));
        check_eq("idex_bubble", 64'(idex_bubble), 64'(e.bub));
        check_eq("halted", 64'(halted), 64'(e.hl));
        check_eq("stall_cycles", 64'(stall_cycles), 64'(m_stall));
        check_eq("redirect_count", 64'(redirect_count), 64'(m_redir));
        @(posedge clk);
        if (!e.pw && !e.hl && m_stall != 32'hFFFF_FFFF) m_stall++;
        if (e.bt && m_redir != 32'hFFFF_FFFF) m_redir++;
        m_halted = nh; m_pend = np; m_tgt = nt;
        #1;
    endtask

    // Assert reset (possibly mid-cycle), check immediate zeroing, release after next edge
    task automatic do_reset();
        reset = 1'b0;
        #1;
        check_eq("rst_pc_write", 64'(pc_write), 64'd0);
        check_eq("rst_branch_taken", 64'(pc_branch_taken), 64'd0);
        check_eq("rst_branch_target", pc_branch_target, 64'd0);
        check_eq("rst_ifid_write", 64'(ifid_write), 64'd0);
        check_eq("rst_ifid_flush", 64'(ifid_flush), 64'd0);
        check_eq("rst_idex_bubble", 64'(idex_bubble), 64'd0);
        check_eq("rst_halted", 64'(halted), 64'd0);
        check_eq("rst_stall_cycles", 64'(stall_cycles), 64'd0);
        check_eq("rst_redirect_count", 64'(redirect_count), 64'd0);
        m_halted = 1'b0; m_pend = 1'b0; m_tgt = 64'd0; m_stall = 32'd0; m_redir = 32'd0;
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        set_idle();
        #3;
        do_reset();

        // Free-running fetch
        for (int i = 0; i < 4; i++) step();
        check_eq("t1_pc", pc, 64'd16);
        check_eq("t1_stall", 64'(stall_cycles), 64'd0);

        // Load-use stall, then r0 destination which must not stall
        ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1'b1;
        step();
        check_eq("t2_stall", 64'(stall_cycles), 64'd1);
        check_eq("t2_pc_held", pc, 64'd16);
        ex_rd = 5'd0; id_rs1 = 5'd0;
        step();
        check_eq("t2_r0_stall", 64'(stall_cycles), 64'd1);
        check_eq("t2_r0_pc", pc, 64'd20);
        set_idle();

        // Immediate redirect
        ex_branch_taken = 1'b1; ex_branch_target = 64'd100;
        step();
        check_eq("t3_pc_target", pc, 64'd100);
        set_idle();
        step();
        check_eq("t3_pc_next", pc, 64'd104);
        check_eq("t3_redirects", 64'(redirect_count), 64'd1);

        // Redirect waiting on the in-flight fetch, with load-use noise ignored
        ex_branch_taken = 1'b1; ex_branch_target = 64'd200; imem_ready = 1'b0;
        step();
        ex_branch_taken = 1'b0;
        ex_mem_read = 1'b1; ex_rd = 5'd7; id_rs2 = 5'd7; id_use_rs2 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("t4_pc_held", pc, 64'd104);
        end
        imem_ready = 1'b1;
        step();
        check_eq("t4_pc_target", pc, 64'd200);
        check_eq("t4_redirects", 64'(redirect_count), 64'd2);
        set_idle();

        // Data-memory stall with a held branch
        dmem_busy = 1'b1; ex_branch_taken = 1'b1; ex_branch_target = 64'd300;
        for (int i = 0; i < 2; i++) begin
            step();
            check_eq("t5_pc_frozen", pc, 64'd200);
        end
        dmem_busy = 1'b0;
        step();
        check_eq("t5_pc_target", pc, 64'd300);
        check_eq("t5_redirects", 64'(redirect_count), 64'd3);
        set_idle();

        // Halt at PC=12
        do_reset();
        for (int i = 0; i < 3; i++) step();
        check_eq("t6_pc_before_halt", pc, 64'd12);
        id_halt = 1'b1;
        step();
        id_halt = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            check_eq("t6_pc_frozen", pc, 64'd12);
            check_eq("t6_halted", 64'(halted), 64'd1);
        end

        // Reset in the middle of a pending redirect drops it
        do_reset();
        ex_branch_taken = 1'b1; ex_branch_target = 64'd400; imem_ready = 1'b0;
        step();
        set_idle();
        #2;
        do_reset();
        step();
        check_eq("t6_no_redirect", 64'(redirect_count), 64'd0);
        check_eq("t6_pc_after_reset", pc, 64'd4);

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 500; i++) begin
            imem_ready       = ($urandom_range(0, 3) != 0);
            dmem_busy        = ($urandom_range(0, 5) == 0);
            id_rs1           = 5'($urandom_range(0, 3));
            id_rs2           = 5'($urandom_range(0, 3));
            ex_rd            = 5'($urandom_range(0, 3));
            id_use_rs1       = 1'($urandom_range(0, 1));
            id_use_rs2       = 1'($urandom_range(0, 1));
            ex_mem_read      = 1'($urandom_range(0, 1));
            ex_branch_taken  = ($urandom_range(0, 4) == 0);
            ex_branch_target = {$urandom, $urandom};
            id_halt          = ($urandom_range(0, 39) == 0);
            step();
            if ($urandom_range(0, 79) == 0 || (m_halted && $urandom_range(0, 7) == 0)) begin
                #2;
                do_reset();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_fetch_controller.md
Name: pc_fetch_controller

Overview:
- Front-end sequencer for the 64-bit PC unit.
- Decides each cycle whether the PC advances, holds, or redirects to a branch target.
- Generates the IF/ID write, IF/ID flush and ID/EX bubble controls for load-use hazards, data-memory stalls, instruction-fetch wait states, taken branches and halt.
- Sits between the hazard sources (ID/EX/MEM stages, instruction and data memories) and the PC unit and pipeline registers.

Parameters:
- ADDR_W, 64, PC/branch-target width.
- REG_W, 5, register specifier width.
- CNT_W, 32, width of the performance counters.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low; 0 holds the block in reset.
- imem_ready  input  1  instruction fetch for the current PC completes this cycle.
- dmem_busy  input  1  data memory stalling MEM; freezes the whole front end.
- id_rs1, id_rs2  input  REG_W  source registers of the instruction in ID.
- id_use_rs1, id_use_rs2  input  1  the ID instruction reads rs1/rs2.
- ex_mem_read  input  1  the EX instruction is a load.
- ex_rd  input  REG_W  destination of the EX instruction.
- ex_branch_taken  input  1  the EX branch resolved taken (held while EX is frozen).
- ex_branch_target  input  ADDR_W  resolved target.
- id_halt  input  1  the ID instruction is HALT.
- pc_write  output  1  to PC unit PCWrite.
- pc_branch_taken  output  1  to PC unit BranchTaken.
- pc_branch_target  output  ADDR_W  to PC unit BranchTarget.
- ifid_write  output  1  IF/ID register enable.
- ifid_flush  output  1  IF/ID register clear.
- idex_bubble  output  1  insert a NOP into ID/EX.
- halted  output  1  the core has stopped fetching.
- stall_cycles  output  CNT_W  cycles with pc_write=0 while not halted, saturating.
- redirect_count  output  CNT_W  branch redirects applied, saturating.

Behaviour:
- States: RUN, PEND_REDIRECT, HALTED.
- Reset (reset=0, async):
  - State RUN; pending target register 0; both counters 0; halted=0.
  - Outputs are combinational and become pc_write=0, pc_branch_taken=0, pc_branch_target=0, ifid_write=0, ifid_flush=0, idex_bubble=0.
  - Reset asserted mid-redirect discards the pending target.
- Load-use hazard, lu = ex_mem_read & (ex_rd != 0) & ((id_use_rs1 & ex_rd == id_rs1) | (id_use_rs2 & ex_rd == id_rs2)).
- RUN, priority highest first:
  1. dmem_busy=1: all control outputs 0; ex_branch_taken is ignored because it stays held.
  2. ex_branch_taken=1 and imem_ready=1:
     - Outputs: pc_write=1, pc_branch_taken=1, pc_branch_target=ex_branch_target, ifid_flush=1, idex_bubble=1, ifid_write=0.
     - Overrides lu and id_halt, because the ID instruction is wrong-path.
     - redirect_count increments; state stays RUN.
  3. ex_branch_taken=1 and imem_ready=0:
     - Latch ex_branch_target; go to PEND_REDIRECT.
     - Outputs this cycle: pc_write=0, ifid_flush=1, idex_bubble=1.
  4. lu=1: pc_write=0, ifid_write=0, idex_bubble=1, for exactly the cycles lu holds.
  5. id_halt=1: pc_write=0, ifid_write=0, idex_bubble=1; go to HALTED.
  6. Otherwise: pc_write=imem_ready, ifid_write=imem_ready; when imem_ready=0, ifid_flush=1 so IF/ID carries no stale fetch.
- PEND_REDIRECT (in-flight fetch must finish and is discarded):
  - While imem_ready=0: pc_write=0, ifid_write=0, ifid_flush=1, idex_bubble=1.
  - When imem_ready=1: pc_write=1, pc_branch_taken=1, pc_branch_target=pending target, ifid_flush=1, idex_bubble=1; redirect_count increments; go to RUN.
  - dmem_busy is ignored here, because EX is already flushed.
- HALTED: pc_write=0, ifid_write=0, idex_bubble=1, halted=1; leaves only on reset.
- pc_branch_taken is 0 and pc_branch_target is 0 whenever no redirect is applied that cycle.
- Counters saturate at all-ones.

Test Plan:
1. Reset release, imem_ready=1, no hazards, 4 cycles: pc_write=1 each cycle, PC unit reaches 16; stall_cycles=0.
2. ex_mem_read=1, ex_rd=5, id_rs1=5, id_use_rs1=1 for 1 cycle: pc_write=0, ifid_write=0, idex_bubble=1 for 1 cycle; stall_cycles=1. Repeat with ex_rd=0: no stall.
3. ex_branch_taken=1, target=100, imem_ready=1: same cycle pc_branch_taken=1, ifid_flush=1, idex_bubble=1; next PC=100, then 104; redirect_count=1.
4. Branch to 200 with imem_ready=0 for 3 cycles: PEND_REDIRECT for 3 cycles, PC held, flush asserted; on imem_ready=1 PC becomes 200. Simultaneous lu during this window is ignored.
5. dmem_busy=1 for 2 cycles with ex_branch_taken=1 held: no redirect during busy; redirect applied in the cycle dmem_busy drops.
6. id_halt=1 at PC=12: halted=1 from next cycle, PC frozen at 12 for 10 cycles. reset=0 pulse mid-PEND_REDIRECT: outputs 0 immediately, state RUN, no redirect afterward.
